bram_fp32_adder: RTL and testbench

Storage-and-arithmetic leaf for the pulse-generation path. It contains two parts:
- A single-port, byte-addressed, 32-bit-word block RAM that holds the accumulated fp32 pulse waveform.
- A combinational IEEE-754 single-precision adder that the pulse generator uses to add template samples to words read from the RAM.

The pulse-generator FSM drives both parts. They share one clock and one reset.

---
 rtl/fp32_pkg.sv | 39 +++
 rtl/fp32_adder_core.sv | 86 ++++++++
 rtl/bram_fp32_adder.sv | 63 ++++++
 tb/tb_bram_fp32_adder.sv | 320 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fp32_pkg.sv
// Shared fp32 constants, unpacked-operand record and helpers for the pulse-path adder.
package fp32_pkg;

   localparam int          FP_EXP_W = 8;
   localparam int          FP_MAN_W = 23;
   localparam int          FP_BIAS  = 127;
   localparam logic [31:0] FP_QNAN  = 32'h7FC00000;
   localparam logic [31:0] FP_PINF  = 32'h7F800000;

   // sig carries the hidden bit at the top; it is 0 for zero/subnormal encodings
   typedef struct packed {
      logic                sign;
      logic [FP_EXP_W-1:0] exp;
      logic [FP_MAN_W:0]   sig;
   } fp32_t;

   function automatic fp32_t fp_unpack(input logic [31:0] v);
      fp32_t u;
      u.sign = v[31];
      u.exp  = v[30:23];
      u.sig  = {(v[30:23] != 8'd0), v[22:0]};
      return u;
   endfunction

   function automatic logic [4:0] lzc28(input logic [27:0] v);
      logic [4:0] n;
      logic       found;
      n     = 5'd28;
      found = 1'b0;
      for (int i = 27; i >= 0; i--) begin
         if (!found && v[i]) begin
            n     = 5'(27 - i);
            found = 1'b1;
         end
      end
      return n;
   endfunction

endpackage

// File: rtl/fp32_adder_core.sv
// Combinational IEEE-754 binary32 adder: RNE rounding, subnormals treated as zero,
// single quiet NaN for every invalid case.
module fp32_adder_core (
   input  logic [31:0] a,
   input  logic [31:0] b,
   output logic [31:0] result
);
   import fp32_pkg::*;

   // n[26] is the leading one, n[25:3] the fraction, n[2:0] guard/round/sticky
   function automatic logic [24:0] rne_round(input logic [26:0] n);
      logic up;
      up = n[2] & (n[1] | n[0] | n[3]);
      return {1'b0, n[26:3]} + {24'd0, up};
   endfunction

   fp32_t              ua, ub, big, sml;
   logic               a_nan, b_nan, a_inf, b_inf, a_zero, b_zero, a_ge;
   logic [7:0]         ediff;
   logic [4:0]         sh, lz;
   logic [26:0]        big_ext, sml_ext, sml_sh, aligned, norm;
   logic [27:0]        sum;
   logic signed [9:0]  exp_n, exp_f;
   logic [24:0]        mrnd;
   logic [22:0]        frac;

   always_comb begin
      ua     = fp_unpack(a);
      ub     = fp_unpack(b);
      a_nan  = (ua.exp == 8'hFF) && (ua.sig[22:0] != 23'd0);
      b_nan  = (ub.exp == 8'hFF) && (ub.sig[22:0] != 23'd0);
      a_inf  = (ua.exp == 8'hFF) && (ua.sig[22:0] == 23'd0);
      b_inf  = (ub.exp == 8'hFF) && (ub.sig[22:0] == 23'd0);
      a_zero = (ua.exp == 8'd0);
      b_zero = (ub.exp == 8'd0);

      a_ge = {ua.exp, ua.sig[22:0]} >= {ub.exp, ub.sig[22:0]};
      big  = a_ge ? ua : ub;
      sml  = a_ge ? ub : ua;

      // Alignment saturates at 27: everything past that collapses into sticky
      ediff   = big.exp - sml.exp;
      sh      = (ediff > 8'd27) ? 5'd27 : ediff[4:0];
      big_ext = {big.sig, 3'b000};
      sml_ext = {sml.sig, 3'b000};
      sml_sh  = sml_ext >> sh;
      aligned = {sml_sh[26:1], sml_sh[0] | ((sml_sh << sh) != sml_ext)};

      if (big.sign == sml.sign)
         sum = {1'b0, big_ext} + {1'b0, aligned};
      else
         sum = {1'b0, big_ext} - {1'b0, aligned};

      lz = lzc28(sum);
      if (lz == 5'd0)
         norm = {sum[27:2], sum[1] | sum[0]};
      else
         norm = sum[26:0] << (lz - 5'd1);
      exp_n = $signed({2'b00, big.exp}) + 10'sd1 - $signed({5'b00000, lz});

      mrnd  = rne_round(norm);
      exp_f = exp_n + $signed({9'd0, mrnd[24]});
      frac  = mrnd[24] ? 23'd0 : mrnd[22:0];

      result = {big.sign, exp_f[7:0], frac};
      if (a_nan || b_nan)
         result = FP_QNAN;
      else if (a_inf && b_inf)
         result = (ua.sign != ub.sign) ? FP_QNAN : {ua.sign, FP_PINF[30:0]};
      else if (a_inf)
         result = {ua.sign, FP_PINF[30:0]};
      else if (b_inf)
         result = {ub.sign, FP_PINF[30:0]};
      else if (a_zero && b_zero)
         result = {ua.sign & ub.sign, 31'd0};
      else if (a_zero)
         result = b;
      else if (b_zero)
         result = a;
      else if (sum == 28'd0 || exp_f < 10'sd1)
         result = 32'd0;
      else if (exp_f > 10'sd254)
         result = {big.sign, FP_PINF[30:0]};
   end

endmodule

// File: rtl/bram_fp32_adder.sv
// Pulse-path leaf: byte-addressed read-first block RAM plus the combinational fp32 adder.
// Define BRAM_DOUT_REG_EN to add a second output register (read latency 2).
module bram_fp32_adder #(
   parameter int DEPTH = 4096,
   parameter int AW    = 12
) (
   input  logic        clka,
   input  logic        rsta,
   input  logic        ena,
   input  logic        wea,
   input  logic [31:0] addra,
   input  logic [31:0] dina,
   output logic [31:0] douta,
   input  logic [31:0] add_a,
   input  logic [31:0] add_b,
   output logic [31:0] add_result
);

   logic [31:0]   mem [DEPTH] = '{default: 32'h0};
   logic [AW-1:0] idx;
   logic [31:0]   dout_p1;
   logic          addr_unused;

   // Byte lane bits and anything above the array wrap are don't-care
   assign idx         = addra[AW+1:2];
   assign addr_unused = ^{addra[31:AW+2], addra[1:0]};

   always_ff @(posedge clka) begin
      if (ena && wea && !rsta)
         mem[idx] <= dina;
   end

   // Stage p1: read-first array register
   always_ff @(posedge clka) begin
      if (rsta)
         dout_p1 <= 32'd0;
      else if (ena)
         dout_p1 <= mem[idx];
   end

`ifdef BRAM_DOUT_REG_EN
   logic [31:0] dout_p2;

   // Stage p2: free-running output register
   always_ff @(posedge clka) begin
      if (rsta)
         dout_p2 <= 32'd0;
      else
         dout_p2 <= dout_p1;
   end

   assign douta = dout_p2;
`else
   assign douta = dout_p1;
`endif

   fp32_adder_core u_adder (
      .a      (add_a),
      .b      (add_b),
      .result (add_result)
   );

endmodule

// File: tb/tb_bram_fp32_adder.sv
// Self-checking bench for bram_fp32_adder: RAM against a word-array model, adder against
// an exact wide-integer reference with round-to-nearest-even.
module tb_bram_fp32_adder;

   localparam int DEPTH = 4096;
   localparam int AW    = 12;
`ifdef BRAM_DOUT_REG_EN
   localparam int LAT = 2;
`else
   localparam int LAT = 1;
`endif
   localparam logic [31:0] TMPL = 32'h3D7C5048;

   logic        clk = 1'b0;
   logic        rsta, ena, wea;
   logic [31:0] addra, dina, douta, add_a, add_b, add_result;

   int checks = 0;
   int errors = 0;
   logic [31:0] model [DEPTH];

   bram_fp32_adder #(.DEPTH(DEPTH), .AW(AW)) dut (
      .clka       (clk),
      .rsta       (rsta),
      .ena        (ena),
      .wea        (wea),
      .addra      (addra),
      .dina       (dina),
      .douta      (douta),
      .add_a      (add_a),
      .add_b      (add_b),
      .add_result (add_result)
   );

   always #5 clk = ~clk;

   function automatic int widx(input logic [31:0] a);
      return int'(a[AW+1:2]);
   endfunction

   // Exact sum on a 300-bit grid, then a single RNE rounding to 24 significant bits
   function automatic logic [31:0] ref_add(input logic [31:0] a, input logic [31:0] b);
      logic [299:0] one, ma, mb, mag, rem, half, sigv;
      int           ea, eb, emin, p, k, e;
      logic         sa, sb, sr;
      logic [7:0]   e8;
      one = 300'd1;
      sa  = a[31];
      sb  = b[31];
      ea  = int'(a[30:23]);
      eb  = int'(b[30:23]);
      if ((ea == 255 && a[22:0] != 23'd0) || (eb == 255 && b[22:0] != 23'd0)) return 32'h7FC00000;
      if (ea == 255 && eb == 255) return (sa != sb) ? 32'h7FC00000 : a;
      if (ea == 255) return a;
      if (eb == 255) return b;
      if (ea == 0 && eb == 0) return {sa & sb, 31'd0};
      if (ea == 0) return b;
      if (eb == 0) return a;
      emin = (ea < eb) ? ea : eb;
      ma = {276'd0, 1'b1, a[22:0]} << (ea - emin);
      mb = {276'd0, 1'b1, b[22:0]} << (eb - emin);
      if (sa == sb) begin
         mag = ma + mb; sr = sa;
      end else if (ma >= mb) begin
         mag = ma - mb; sr = sa;
      end else begin
         mag = mb - ma; sr = sb;
      end
      if (mag == 300'd0) return 32'h0;
      p = 0;
      for (int i = 0; i < 300; i++) if (mag[i]) p = i;
      if (p > 23) begin
         k    = p - 23;
         sigv = mag >> k;
         rem  = mag & ((one << k) - one);
         half = one << (k - 1);
         if (rem > half || (rem == half && sigv[0])) sigv = sigv + one;
         if (sigv[24]) begin
            sigv = sigv >> 1;
            p    = p + 1;
         end
      end else begin
         sigv = mag << (23 - p);
      end
      e = p + emin - 23;
      if (e <= 0) return 32'h0;
      if (e >= 255) return {sr, 8'hFF, 23'd0};
      e8 = 8'(e);
      return {sr, e8, sigv[22:0]};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One RAM access; on return douta holds that access's read data
   task automatic ram_cycle(input logic we, input logic [31:0] addr, input logic [31:0] din);
      ena = 1'b1; wea = we; addra = addr; dina = din;
      tick();
      ena = 1'b0; wea = 1'b0;
      if (LAT == 2) tick();
   endtask

   task automatic ram_write(input logic [31:0] addr, input logic [31:0] din);
      ram_cycle(1'b1, addr, din);
      model[widx(addr)] = din;
   endtask

   task automatic ram_read_check(input string name, input logic [31:0] addr, input logic [31:0] exp);
      ram_cycle(1'b0, addr, 32'h0);
      checks++;
      if (douta !== exp) begin
         errors++;
         $display("FAIL %s addr=%h douta=%h expected=%h", name, addr, douta, exp);
      end
   endtask

   task automatic test_reset();
      rsta = 1'b1; ena = 1'b0; wea = 1'b0; addra = 32'h0; dina = 32'h0;
      add_a = 32'h0; add_b = 32'h0;
      tick(); tick();
      checks++;
      if (douta !== 32'h0) begin
         errors++;
         $display("FAIL reset_initial douta=%h expected=00000000", douta);
      end
      rsta = 1'b0;
      ram_write(32'h200, 32'h12345678);
      ram_read_check("reset_pre_read", 32'h200, 32'h12345678);
      tick(); tick();
      // A write request held during reset must be ignored
      rsta = 1'b1; ena = 1'b1; wea = 1'b1; addra = 32'h200; dina = 32'hDEADBEEF;
      tick();
      checks++;
      if (douta !== 32'h0) begin
         errors++;
         $display("FAIL reset_clear douta=%h expected=00000000", douta);
      end
      rsta = 1'b0; ena = 1'b0; wea = 1'b0;
      ram_read_check("reset_no_write", 32'h200, model[widx(32'h200)]);
      ram_read_check("reset_unwritten", 32'h3F0, 32'h0);
   endtask

   task automatic test_write_read();
      ram_write(32'h10, 32'h3E99652C);
      ram_read_check("write_read", 32'h10, 32'h3E99652C);
      ram_cycle(1'b1, 32'h10, 32'h3D7C5048);
      checks++;
      if (douta !== 32'h3E99652C) begin
         errors++;
         $display("FAIL read_first douta=%h expected=3e99652c", douta);
      end
      model[widx(32'h10)] = 32'h3D7C5048;
      ram_read_check("write_after_rf", 32'h10, 32'h3D7C5048);
   endtask

   task automatic test_addr();
      ram_write(32'h13, 32'h3F800000);
      ram_read_check("addr_byte_lane", 32'h10, 32'h3F800000);
      ram_write(32'(4 * DEPTH), 32'h40490FDB);
      ram_read_check("addr_wrap", 32'h0, 32'h40490FDB);
   endtask

   task automatic test_enable_hold();
      logic [31:0] held;
      ram_read_check("hold_setup", 32'h10, model[widx(32'h10)]);
      held = douta;
      ena = 1'b0; wea = 1'b1; addra = 32'h0; dina = 32'hAAAA5555;
      tick(); tick();
      wea = 1'b0;
      checks++;
      if (douta !== held) begin
         errors++;
         $display("FAIL ena_hold douta=%h expected=%h", douta, held);
      end
      ram_read_check("ena_no_write", 32'h0, model[0]);
   endtask

   task automatic test_back_to_back();
      localparam int N = 16;
      logic [31:0] base, data [N], old [N];
      int j;
      base = 32'h2000;
      for (int i = 0; i < N; i++) begin
         data[i] = $urandom;
         old[i]  = model[widx(base + 32'(4 * i))];
      end
      for (int i = 0; i < N + LAT - 1; i++) begin
         if (i < N) begin
            ena = 1'b1; wea = 1'b1; addra = base + 32'(4 * i); dina = data[i];
         end else begin
            ena = 1'b0; wea = 1'b0;
         end
         tick();
         j = i - (LAT - 1);
         if (j >= 0) begin
            checks++;
            if (douta !== old[j]) begin
               errors++;
               $display("FAIL b2b_write_rf idx=%0d douta=%h expected=%h", j, douta, old[j]);
            end
         end
      end
      for (int i = 0; i < N; i++) model[widx(base + 32'(4 * i))] = data[i];
      for (int i = 0; i < N + LAT - 1; i++) begin
         if (i < N) begin
            ena = 1'b1; wea = 1'b0; addra = base + 32'(4 * i);
         end else begin
            ena = 1'b0;
         end
         tick();
         j = i - (LAT - 1);
         if (j >= 0) begin
            checks++;
            if (douta !== data[j]) begin
               errors++;
               $display("FAIL b2b_read idx=%0d douta=%h expected=%h", j, douta, data[j]);
            end
         end
      end
      ena = 1'b0;
   endtask

   task automatic test_adder_directed();
      logic [31:0] va [8] = '{32'h00000000, 32'h3D7C5048, 32'h3F800000, 32'h3F800000,
                              32'h3F800000, 32'h7F7FFFFF, 32'h7F800000, 32'h3F800000};
      logic [31:0] vb [8] = '{32'h3D7C5048, 32'h3D7C5048, 32'h3F800000, 32'h3F000000,
                              32'hBF800000, 32'h7F7FFFFF, 32'hFF800000, 32'h33800000};
      logic [31:0] vr [8] = '{32'h3D7C5048, 32'h3DFC5048, 32'h40000000, 32'h3FC00000,
                              32'h00000000, 32'h7F800000, 32'h7FC00000, 32'h3F800000};
      for (int i = 0; i < 8; i++) begin
         add_a = va[i]; add_b = vb[i];
         #1;
         checks++;
         if (add_result !== vr[i]) begin
            errors++;
            $display("FAIL add_directed_%0d %h+%h result=%h expected=%h", i, va[i], vb[i], add_result, vr[i]);
         end
      end
   endtask

   task automatic test_adder_random();
      logic [31:0] a, b, exp;
      int mode;
      for (int i = 0; i < 500; i++) begin
         mode = i % 5;
         a = $urandom;
         b = $urandom;
         case (mode)
            1: begin
               a[30:23] = 8'($urandom_range(110, 140));
               b[30:23] = 8'($urandom_range(110, 140));
            end
            2: begin
               a[30:23] = 8'($urandom_range(20, 230));
               b = {~a[31], a[30:23] + 8'($urandom_range(0, 1)), a[22:0] ^ 23'($urandom_range(0, 255))};
            end
            3: begin
               a[30:23] = 8'($urandom_range(248, 254));
               b[30:23] = 8'($urandom_range(248, 254));
               b[31] = a[31];
            end
            4: begin
               a[30:23] = 8'($urandom_range(1, 3));
               b[30:23] = 8'($urandom_range(1, 3));
               b[31] = ~a[31];
            end
            default: ;
         endcase
         add_a = a; add_b = b;
         #1;
         exp = ref_add(a, b);
         checks++;
         if (add_result !== exp) begin
            errors++;
            $display("FAIL add_random mode=%0d %h+%h result=%h expected=%h", mode, a, b, add_result, exp);
         end
      end
   endtask

   task automatic test_rmw();
      logic [31:0] q, exp, addr;
      for (int pass = 0; pass < 2; pass++) begin
         for (int w = 0; w < 13; w++) begin
            addr = 32'h40 + 32'(4 * w);
            ram_read_check("rmw_read", addr, model[widx(addr)]);
            q = douta;
            add_a = q; add_b = TMPL;
            #1;
            exp = ref_add(q, TMPL);
            checks++;
            if (add_result !== exp) begin
               errors++;
               $display("FAIL rmw_add w=%0d result=%h expected=%h", w, add_result, exp);
            end
            ram_write(addr, add_result);
         end
      end
      for (int w = 0; w < 13; w++)
         ram_read_check("rmw_final", 32'h40 + 32'(4 * w), 32'h3DFC5048);
      ram_read_check("rmw_below", 32'h3C, 32'h0);
      ram_read_check("rmw_above", 32'h74, 32'h0);
   endtask

   initial begin
      for (int i = 0; i < DEPTH; i++) model[i] = 32'h0;
      test_reset();
      test_write_read();
      test_addr();
      test_enable_hold();
      test_back_to_back();
      test_adder_directed();
      test_adder_random();
      test_rmw();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
